// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : UART receiver clocked by clk, paced by a 16x oversampling tick.
//   Samples the synchronised serial line at mid-bit, deserialises LSB-first
//   frames, optionally checks parity and validates the stop bit.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   rx         in   serial line (idle high), asynchronous to clk
//   s_tick     in   oversampling tick, one clk wide
//   rx_data    out  last received word (DBIT bits)
//   rx_done    out  one-clk pulse when a frame completes
//   frame_err  out  stop bit sampled low on the last frame
//   parity_err out  parity mismatch on the last frame
//   busy       out  high whenever the receiver is not idle
//
// state  | meaning
// IDLE   | waiting for rx_s low (checked every clk, not gated by s_tick)
// START  | counting to the middle of the start bit, rejecting glitches
// DATA   | sampling DBIT data bits, one per NUM_TICKS ticks
// PARITY | sampling the parity bit
// STOP   | waiting SB_TICK ticks, then sampling the stop bit and reporting
// ---------------------------------------------------------------------------
module uart_rx #(
   parameter int DBIT       = 8,
   parameter int NUM_TICKS  = 16,
   parameter int SB_TICK    = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            rx,
   input  logic            s_tick,
   output logic [DBIT-1:0] rx_data,
   output logic            rx_done,
   output logic            frame_err,
   output logic            parity_err,
   output logic            busy
);

   localparam int S_MAX = (NUM_TICKS > SB_TICK) ? NUM_TICKS : SB_TICK;
   localparam int S_W   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
   localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [S_W-1:0] S_MID      = S_W'(NUM_TICKS / 2 - 1);
   localparam logic [S_W-1:0] S_BIT_LAST = S_W'(NUM_TICKS - 1);
   localparam logic [S_W-1:0] S_SB_LAST  = S_W'(SB_TICK - 1);
   localparam logic [N_W-1:0] N_LAST     = N_W'(DBIT - 1);
   localparam logic           PAR_EN     = (PARITY_EN != 0);
   localparam logic           PAR_ODD    = (PARITY_ODD != 0);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   logic            rx_meta_q, rx_s_q;
   logic [2:0]      state_q, state_d;
   logic [S_W-1:0]  s_q, s_d;
   logic [N_W-1:0]  n_q, n_d;
   logic [DBIT-1:0] b_q, b_d;
   logic            p_q, p_d;
   logic [DBIT-1:0] rx_data_q, rx_data_d;
   logic            rx_done_q, rx_done_d;
   logic            frame_err_q, frame_err_d;
   logic            parity_err_q, parity_err_d;

   always_comb begin
      state_d      = state_q;
      s_d          = s_q;
      n_d          = n_q;
      b_d          = b_q;
      p_d          = p_q;
      rx_data_d    = rx_data_q;
      rx_done_d    = 1'b0;
      frame_err_d  = frame_err_q;
      parity_err_d = parity_err_q;

      case (state_q)
         IDLE: begin
            if (!rx_s_q) begin
               state_d = START;
               s_d     = '0;
            end
         end
         START: begin
            if (s_tick) begin
               if (s_q == S_MID) begin
                  if (!rx_s_q) begin
                     state_d = DATA;
                     s_d     = '0;
                     n_d     = '0;
                  end else begin
                     // start bit vanished before mid-point: treat as a glitch
                     state_d = IDLE;
                  end
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s_q == S_BIT_LAST) begin
                  s_d = '0;
                  b_d = {rx_s_q, b_q[DBIT-1:1]};
                  if (n_q == N_LAST) begin
                     state_d = PAR_EN ? PARITY : STOP;
                  end else begin
                     n_d = n_q + 1'b1;
                  end
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         PARITY: begin
            if (s_tick) begin
               if (s_q == S_BIT_LAST) begin
                  p_d     = rx_s_q;
                  s_d     = '0;
                  state_d = STOP;
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (s_q == S_SB_LAST) begin
                  rx_data_d    = b_q;
                  frame_err_d  = ~rx_s_q;
                  parity_err_d = PAR_EN & (((^b_q) ^ p_q) != PAR_ODD);
                  rx_done_d    = 1'b1;
                  state_d      = IDLE;
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q    <= 1'b1;
         rx_s_q       <= 1'b1;
         state_q      <= IDLE;
         s_q          <= '0;
         n_q          <= '0;
         b_q          <= '0;
         p_q          <= 1'b0;
         rx_data_q    <= '0;
         rx_done_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         rx_meta_q    <= rx;
         rx_s_q       <= rx_meta_q;
         state_q      <= state_d;
         s_q          <= s_d;
         n_q          <= n_d;
         b_q          <= b_d;
         p_q          <= p_d;
         rx_data_q    <= rx_data_d;
         rx_done_q    <= rx_done_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_done    = rx_done_q;
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx : self-checking bench for uart_rx.
//   u0 : 8N1 receiver, u1 : 8E1 receiver (even parity).
//   Frames are built bit by bit at 64 clk per bit (s_tick every 4 clk).
//   The expected outcome of each frame (data, framing, parity) is computed
//   from the frame contents and queued; a monitor pops it on rx_done.
// ---------------------------------------------------------------------------
module tb_uart_rx;

   localparam int BIT_CLK = 64;

   typedef struct packed {
      logic [7:0] data;
      logic       ferr;
      logic       perr;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       s_tick;
   logic       rx0, rx1;
   logic [7:0] rx_data0, rx_data1;
   logic       rx_done0, rx_done1;
   logic       frame_err0, frame_err1;
   logic       parity_err0, parity_err1;
   logic       busy0, busy1;

   int checks = 0;
   int errors = 0;

   exp_t exp_q0[$];
   exp_t exp_q1[$];
   int   sent0 = 0, sent1 = 0;
   int   done_cnt0 = 0, done_cnt1 = 0;
   int   tick_num = 0;
   int   t_prev0 = 0, t_last0 = 0;
   logic [7:0] last_data0 = '0;
   logic       last_ferr0 = 1'b0;

   uart_rx #(.DBIT(8), .NUM_TICKS(16), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
      .clk(clk), .rst_n(rst_n), .rx(rx0), .s_tick(s_tick),
      .rx_data(rx_data0), .rx_done(rx_done0), .frame_err(frame_err0),
      .parity_err(parity_err0), .busy(busy0)
   );

   uart_rx #(.DBIT(8), .NUM_TICKS(16), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
      .clk(clk), .rst_n(rst_n), .rx(rx1), .s_tick(s_tick),
      .rx_data(rx_data1), .rx_done(rx_done1), .frame_err(frame_err1),
      .parity_err(parity_err1), .busy(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      int phase;
      phase  = 0;
      s_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         phase  = (phase + 1) % 4;
         s_tick = (phase == 0);
         if (s_tick) tick_num++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected result of a frame, from its contents alone
   function automatic exp_t frame_model(input logic [7:0] data, input bit stop_bit,
                                        input bit pbit, input bit par_en);
      exp_t e;
      e.data = data;
      e.ferr = !stop_bit;
      e.perr = par_en && ((($countones(data) + int'(pbit)) % 2) != 0);
      return e;
   endfunction

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_rx(input int line, input logic v);
      if (line == 0) rx0 = v;
      else           rx1 = v;
   endtask

   // A low stop bit is held only part of the bit so that the line is back
   // high before the receiver re-checks it as a possible start bit.
   task automatic send_frame(input int line, input logic [7:0] data, input bit stop_bit,
                             input bit pbit, input int gap);
      if (line == 0) begin
         exp_q0.push_back(frame_model(data, stop_bit, pbit, 1'b0));
         sent0++;
      end else begin
         exp_q1.push_back(frame_model(data, stop_bit, pbit, 1'b1));
         sent1++;
      end
      set_rx(line, 1'b0);
      wait_clk(BIT_CLK);
      for (int i = 0; i < 8; i++) begin
         set_rx(line, data[i]);
         wait_clk(BIT_CLK);
      end
      if (line == 1) begin
         set_rx(line, pbit);
         wait_clk(BIT_CLK);
      end
      if (stop_bit) begin
         set_rx(line, 1'b1);
         wait_clk(BIT_CLK);
      end else begin
         set_rx(line, 1'b0);
         wait_clk(48);
         set_rx(line, 1'b1);
         wait_clk(BIT_CLK - 48);
      end
      set_rx(line, 1'b1);
      if (gap > 0) wait_clk(gap);
   endtask

   initial begin
      exp_t e;
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (prev) chk("done_width0", rx_done0, 0);
         if (rx_done0) begin
            done_cnt0++;
            t_prev0 = t_last0;
            t_last0 = tick_num;
            chk("busy_at_done0", busy0, 0);
            chk("exp_pending0", exp_q0.size() > 0, 1);
            if (exp_q0.size() > 0) begin
               e = exp_q0.pop_front();
               chk("data0", rx_data0, e.data);
               chk("frame_err0", frame_err0, e.ferr);
               chk("parity_err0", parity_err0, e.perr);
               last_data0 = e.data;
               last_ferr0 = e.ferr;
            end
         end
         prev = rx_done0;
      end
   end

   initial begin
      exp_t e;
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (prev) chk("done_width1", rx_done1, 0);
         if (rx_done1) begin
            done_cnt1++;
            chk("busy_at_done1", busy1, 0);
            chk("exp_pending1", exp_q1.size() > 0, 1);
            if (exp_q1.size() > 0) begin
               e = exp_q1.pop_front();
               chk("data1", rx_data1, e.data);
               chk("frame_err1", frame_err1, e.ferr);
               chk("parity_err1", parity_err1, e.perr);
            end
         end
         prev = rx_done1;
      end
   end

   initial begin
      int         dc;
      int         diff;
      logic [7:0] d;
      bit         sb, pb;

      rst_n = 1'b0;
      rx0   = 1'b1;
      rx1   = 1'b1;
      wait_clk(5);
      chk("rst_data", rx_data0, 0);
      chk("rst_done", rx_done0, 0);
      chk("rst_ferr", frame_err0, 0);
      chk("rst_perr", parity_err0, 0);
      chk("rst_busy", busy0, 0);
      rst_n = 1'b1;
      wait_clk(20);

      send_frame(0, 8'hA5, 1'b1, 1'b0, 128);
      chk("a5_one_done", done_cnt0, 1);

      // glitch: 4 ticks low, then high
      dc = done_cnt0;
      rx0 = 1'b0;
      wait_clk(8);
      chk("glitch_busy_hi", busy0, 1);
      wait_clk(8);
      rx0 = 1'b1;
      wait_clk(24);
      chk("glitch_busy_lo", busy0, 0);
      wait_clk(64);
      chk("glitch_no_done", done_cnt0, dc);
      chk("glitch_data", rx_data0, last_data0);
      chk("glitch_ferr", frame_err0, last_ferr0);

      send_frame(0, 8'h3C, 1'b0, 1'b0, 128);
      chk("ferr_set", frame_err0, 1);
      send_frame(0, 8'h11, 1'b1, 1'b0, 128);
      chk("ferr_clr", frame_err0, 0);

      send_frame(1, 8'h07, 1'b1, 1'b1, 128);
      chk("par_good", parity_err1, 0);
      send_frame(1, 8'h07, 1'b1, 1'b0, 128);
      chk("par_bad", parity_err1, 1);
      chk("par_bad_data", rx_data1, 8'h07);

      for (int i = 0; i < 16; i++) begin
         d  = 8'($urandom_range(0, 255));
         sb = ($urandom_range(0, 4) != 0);
         send_frame(0, d, sb, 1'b0, 64 + 4 * $urandom_range(0, 16));
      end
      for (int i = 0; i < 10; i++) begin
         d  = 8'($urandom_range(0, 255));
         sb = ($urandom_range(0, 4) != 0);
         pb = 1'($urandom_range(0, 1));
         send_frame(1, d, sb, pb, 64 + $urandom_range(0, 40));
      end

      // reset after the 3rd data bit of a frame on u0
      send_frame(0, 8'hC3, 1'b1, 1'b0, 128);
      dc = done_cnt0;
      rx0 = 1'b0;
      wait_clk(BIT_CLK);
      rx0 = 1'b1; wait_clk(BIT_CLK);
      rx0 = 1'b0; wait_clk(BIT_CLK);
      rx0 = 1'b1; wait_clk(BIT_CLK);
      chk("pre_rst_busy", busy0, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_data", rx_data0, 0);
      chk("arst_done", rx_done0, 0);
      chk("arst_ferr", frame_err0, 0);
      chk("arst_perr", parity_err0, 0);
      chk("arst_busy", busy0, 0);
      chk("arst_data1", rx_data1, 0);
      rx0 = 1'b1;
      wait_clk(10);
      rst_n = 1'b1;
      last_data0 = '0;
      last_ferr0 = 1'b0;
      wait_clk(BIT_CLK * 6);
      chk("arst_no_done", done_cnt0, dc);
      send_frame(0, 8'h5A, 1'b1, 1'b0, 128);
      chk("post_rst_done", done_cnt0, dc + 1);
      chk("post_rst_data", rx_data0, 8'h5A);

      // back-to-back frames, no idle gap
      send_frame(0, 8'h00, 1'b1, 1'b0, 0);
      send_frame(0, 8'hFF, 1'b1, 1'b0, 128);
      diff = t_last0 - t_prev0;
      chk("b2b_spacing", (diff >= 159 && diff <= 161), 1);
      chk("b2b_last_data", rx_data0, 8'hFF);

      wait_clk(BIT_CLK * 2);
      chk("q0_empty", exp_q0.size(), 0);
      chk("q1_empty", exp_q1.size(), 0);
      chk("done_total0", done_cnt0, sent0);
      chk("done_total1", done_cnt1, sent1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
